// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, sequencer states, control-word layout and opcode grouping helpers.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4,  OP_SHR  = 5'd5,  OP_SHL  = 5'd6,  OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8,  OP_AND  = 5'd9,  OP_OR   = 5'd10, OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14, OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16, OP_NOT  = 5'd17, OP_BRX  = 5'd18, OP_JR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20, OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24, OP_HALT = 5'd26;

    localparam int BUS_HI = 0, BUS_LO = 1, BUS_ZHI = 2, BUS_ZLO = 3;
    localparam int BUS_PC = 4, BUS_MDR = 5, BUS_INPORT = 6, BUS_C = 7;

    localparam int LD_MDR = 0, LD_MAR = 1, LD_Y = 2, LD_ZLO = 3, LD_ZHI = 4, LD_HI = 5;
    localparam int LD_LO = 6, LD_PC = 7, LD_IR = 8, LD_OUTPORT = 9, LD_CON = 10;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_WAIT, S_HALT
    } state_t;

    typedef struct packed {
        logic [7:0]  bus_src;
        logic [10:0] ld_en;
        logic        gra, grb, grc, r_in, r_out, ba_out;
        logic [15:0] reg_en_in;
        logic        mdr_read, ram_enable, pc_increment;
    } ctrl_t;

    function automatic logic is_alu3(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR};
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return op inside {OP_MUL, OP_DIV};
    endfunction

    function automatic logic is_imm(input logic [4:0] op);
        return op inside {OP_LDI, OP_ADDI, OP_ANDI, OP_ORI};
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return op inside {OP_NEG, OP_NOT};
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return op inside {OP_LD, OP_ST};
    endfunction

    function automatic logic is_single(input logic [4:0] op);
        return op inside {OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO};
    endfunction

    // Final step of each instruction; nop, halt and undefined opcodes end after fetch.
    function automatic state_t last_step(input logic [4:0] op);
        return is_mem(op) ? S_T7 :
               (is_muldiv(op) || op == OP_BRX) ? S_T6 :
               (is_alu3(op) || is_imm(op)) ? S_T5 :
               (is_unary(op) || op == OP_JAL) ? S_T4 :
               is_single(op) ? S_T3 : S_T2;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational map from (step, opcode, con_out) to the datapath control word.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned LINK_REG = 15
) (
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con_out,
    output ctrl_t      cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_T0: begin
                cw.bus_src[BUS_PC] = 1'b1;
                cw.ld_en[LD_MAR] = 1'b1;
                cw.pc_increment = 1'b1;
            end
            S_T1: begin
                cw.mdr_read = 1'b1;
                cw.ld_en[LD_MDR] = 1'b1;
            end
            S_T2: begin
                cw.bus_src[BUS_MDR] = 1'b1;
                cw.ld_en[LD_IR] = 1'b1;
            end
            S_T3: begin
                if (is_alu3(opcode) || is_muldiv(opcode) || is_imm(opcode)) begin
                    cw.grb = 1'b1;
                    cw.ba_out = opcode == OP_LDI;
                    cw.r_out = opcode != OP_LDI;
                    cw.ld_en[LD_Y] = 1'b1;
                end
                if (is_unary(opcode)) begin
                    cw.grb = 1'b1;
                    cw.r_out = 1'b1;
                    cw.ld_en[LD_ZLO] = 1'b1;
                end
                if (is_mem(opcode)) begin
                    cw.grb = 1'b1;
                    cw.ba_out = 1'b1;
                    cw.ld_en[LD_Y] = 1'b1;
                end
                if (opcode == OP_BRX || opcode == OP_JR || opcode == OP_OUT) begin
                    cw.gra = 1'b1;
                    cw.r_out = 1'b1;
                    cw.ld_en[LD_CON] = opcode == OP_BRX;
                    cw.ld_en[LD_PC] = opcode == OP_JR;
                    cw.ld_en[LD_OUTPORT] = opcode == OP_OUT;
                end
                if (opcode == OP_JAL) begin
                    cw.bus_src[BUS_PC] = 1'b1;
                    cw.reg_en_in = 16'h1 << LINK_REG;
                end
                if (opcode inside {OP_IN, OP_MFHI, OP_MFLO}) begin
                    cw.gra = 1'b1;
                    cw.r_in = 1'b1;
                    cw.bus_src[BUS_INPORT] = opcode == OP_IN;
                    cw.bus_src[BUS_HI] = opcode == OP_MFHI;
                    cw.bus_src[BUS_LO] = opcode == OP_MFLO;
                end
            end
            S_T4: begin
                if (is_alu3(opcode) || is_muldiv(opcode)) begin
                    cw.grc = 1'b1;
                    cw.r_out = 1'b1;
                    cw.ld_en[LD_ZLO] = 1'b1;
                    cw.ld_en[LD_ZHI] = is_muldiv(opcode);
                end
                if (is_imm(opcode) || is_mem(opcode)) begin
                    cw.bus_src[BUS_C] = 1'b1;
                    cw.ld_en[LD_ZLO] = 1'b1;
                end
                if (is_unary(opcode)) begin
                    cw.bus_src[BUS_ZLO] = 1'b1;
                    cw.gra = 1'b1;
                    cw.r_in = 1'b1;
                end
                if (opcode == OP_BRX) begin
                    cw.bus_src[BUS_PC] = 1'b1;
                    cw.ld_en[LD_Y] = 1'b1;
                end
                if (opcode == OP_JAL) begin
                    cw.gra = 1'b1;
                    cw.r_out = 1'b1;
                    cw.ld_en[LD_PC] = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu3(opcode) || is_imm(opcode)) begin
                    cw.bus_src[BUS_ZLO] = 1'b1;
                    cw.gra = 1'b1;
                    cw.r_in = 1'b1;
                end
                if (is_muldiv(opcode) || is_mem(opcode)) begin
                    cw.bus_src[BUS_ZLO] = 1'b1;
                    cw.ld_en[LD_LO] = is_muldiv(opcode);
                    cw.ld_en[LD_MAR] = is_mem(opcode);
                end
                if (opcode == OP_BRX) begin
                    cw.bus_src[BUS_C] = 1'b1;
                    cw.ld_en[LD_ZLO] = 1'b1;
                end
            end
            S_T6: begin
                if (is_muldiv(opcode)) begin
                    cw.bus_src[BUS_ZHI] = 1'b1;
                    cw.ld_en[LD_HI] = 1'b1;
                end
                if (opcode == OP_LD) begin
                    cw.mdr_read = 1'b1;
                    cw.ld_en[LD_MDR] = 1'b1;
                end
                if (opcode == OP_ST) begin
                    cw.gra = 1'b1;
                    cw.r_out = 1'b1;
                    cw.ld_en[LD_MDR] = 1'b1;
                end
                if (opcode == OP_BRX && con_out) begin
                    cw.bus_src[BUS_ZLO] = 1'b1;
                    cw.ld_en[LD_PC] = 1'b1;
                end
            end
            S_T7: begin
                if (opcode == OP_LD) begin
                    cw.bus_src[BUS_MDR] = 1'b1;
                    cw.gra = 1'b1;
                    cw.r_in = 1'b1;
                end
                cw.ram_enable = opcode == OP_ST;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute step sequencer with run/halt/restart.
// Optional SINGLE_STEP_EN adds step_mode, which halts after every instruction.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned LINK_REG = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  opcode,
    input  logic        con_out,
    input  logic        start,
    input  logic        stop,
`ifdef SINGLE_STEP_EN
    input  logic        step_mode,
`endif
    output logic [7:0]  bus_src,
    output logic [10:0] ld_en,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic        ba_out,
    output logic [15:0] reg_en_in,
    output logic        mdr_read,
    output logic        ram_enable,
    output logic        pc_increment,
    output logic        run
);

    state_t     state, nxt;
    logic [2:0] wcnt;
    logic       stop_q, halt_req, ram_step, hold;
    ctrl_t      cw;

`ifdef SINGLE_STEP_EN
    assign halt_req = stop_q | stop | step_mode;
`else
    assign halt_req = stop_q | stop;
`endif

    // RAM steps stretch for MEM_WAIT extra cycles while the counter drains.
    assign ram_step = state == S_T1 || (state == S_T6 && opcode == OP_LD) ||
                      (state == S_T7 && opcode == OP_ST);
    assign hold = ram_step && wcnt != 3'd0;

    always_comb begin
        nxt = state == S_RST || state == S_WAIT ? S_T0 :
              state == S_HALT ? (start ? S_T0 : S_HALT) :
              hold ? state :
              state != last_step(opcode) ? state_t'(state + 4'd1) :
              (halt_req || opcode == OP_HALT) ? S_HALT : S_T0;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_RST;
            wcnt <= 3'(MEM_WAIT);
            stop_q <= 1'b0;
        end else begin
            state <= nxt;
            wcnt <= hold ? wcnt - 3'd1 : 3'(MEM_WAIT);
            stop_q <= (state == S_HALT || nxt == S_HALT) ? 1'b0 : stop_q | stop;
        end
    end

    ctrl_decode #(.LINK_REG(LINK_REG)) u_decode (
        .state  (state),
        .opcode (opcode),
        .con_out(con_out),
        .cw     (cw)
    );

    assign bus_src = cw.bus_src;
    assign ld_en = cw.ld_en;
    assign gra = cw.gra;
    assign grb = cw.grb;
    assign grc = cw.grc;
    assign r_in = cw.r_in;
    assign r_out = cw.r_out;
    assign ba_out = cw.ba_out;
    assign reg_en_in = cw.reg_en_in;
    assign mdr_read = cw.mdr_read;
    assign ram_enable = cw.ram_enable;
    assign pc_increment = cw.pc_increment;
    assign run = state inside {[S_T0:S_T7]};

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction stream checked against a per-instruction step-list model.
module tb_control_sequencer;

    localparam int MW = 2;
    localparam int LINK = 9;

    localparam int B_HI = 0, B_LO = 1, B_ZHI = 2, B_ZLO = 3, B_PC = 4, B_MDR = 5, B_IN = 6, B_C = 7;
    localparam logic [10:0] L_MDR = 11'h001, L_MAR = 11'h002, L_Y = 11'h004, L_ZLO = 11'h008;
    localparam logic [10:0] L_ZHI = 11'h010, L_HI = 11'h020, L_LO = 11'h040, L_PC = 11'h080;
    localparam logic [10:0] L_IR = 11'h100, L_OUT = 11'h200, L_CON = 11'h400;
    localparam logic [5:0] GRA = 6'b100000, GRB = 6'b010000, GRC = 6'b001000;
    localparam logic [5:0] RIN = 6'b000100, ROUT = 6'b000010, BA = 6'b000001;
    localparam logic [2:0] MRD = 3'b100, RAM = 3'b010, PCI = 3'b001;

    logic        clk = 1'b0, clr = 1'b0, con_out = 1'b0, start = 1'b0, stop = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic [7:0]  bus_src;
    logic [10:0] ld_en;
    logic        gra, grb, grc, r_in, r_out, ba_out, mdr_read, ram_enable, pc_increment, run;
    logic [15:0] reg_en_in;
    logic [44:0] outs;
    logic [44:0] q[$];
    int          checks = 0, failures = 0;
    bit          pend = 1'b0;

    always #5 clk = ~clk;

    control_sequencer #(.MEM_WAIT(MW), .LINK_REG(LINK)) dut (
        .clk(clk), .clr(clr), .opcode(opcode), .con_out(con_out), .start(start), .stop(stop),
`ifdef SINGLE_STEP_EN
        .step_mode(1'b0),
`endif
        .bus_src(bus_src), .ld_en(ld_en), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in),
        .r_out(r_out), .ba_out(ba_out), .reg_en_in(reg_en_in), .mdr_read(mdr_read),
        .ram_enable(ram_enable), .pc_increment(pc_increment), .run(run)
    );

    assign outs = {bus_src, ld_en, gra, grb, grc, r_in, r_out, ba_out, reg_en_in,
                   mdr_read, ram_enable, pc_increment, run};

    task automatic check(input string tag, input logic [44:0] got, input logic [44:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [44:0] w(input int bus, input logic [10:0] ld, input logic [5:0] sel,
                                      input logic [2:0] mem, input bit link);
        logic [7:0] b;
        b = bus < 0 ? 8'h00 : 8'(1 << bus);
        return {b, ld, sel, link ? 16'(1 << LINK) : 16'h0000, mem, 1'b1};
    endfunction

    // Expected per-cycle control words of one instruction, RAM steps already stretched.
    function automatic void expand(input logic [4:0] op, input bit con);
        q.delete();
        q.push_back(w(B_PC, L_MAR, 0, PCI, 0));
        repeat (MW + 1) q.push_back(w(-1, L_MDR, 0, MRD, 0));
        q.push_back(w(B_MDR, L_IR, 0, 0, 0));
        if (op inside {[3:10]}) begin
            q.push_back(w(-1, L_Y, GRB | ROUT, 0, 0));
            q.push_back(w(-1, L_ZLO, GRC | ROUT, 0, 0));
            q.push_back(w(B_ZLO, 0, GRA | RIN, 0, 0));
        end else if (op inside {14, 15}) begin
            q.push_back(w(-1, L_Y, GRB | ROUT, 0, 0));
            q.push_back(w(-1, L_ZLO | L_ZHI, GRC | ROUT, 0, 0));
            q.push_back(w(B_ZLO, L_LO, 0, 0, 0));
            q.push_back(w(B_ZHI, L_HI, 0, 0, 0));
        end else if (op inside {1, 11, 12, 13}) begin
            q.push_back(w(-1, L_Y, op == 1 ? GRB | BA : GRB | ROUT, 0, 0));
            q.push_back(w(B_C, L_ZLO, 0, 0, 0));
            q.push_back(w(B_ZLO, 0, GRA | RIN, 0, 0));
        end else if (op inside {16, 17}) begin
            q.push_back(w(-1, L_ZLO, GRB | ROUT, 0, 0));
            q.push_back(w(B_ZLO, 0, GRA | RIN, 0, 0));
        end else if (op inside {0, 2}) begin
            q.push_back(w(-1, L_Y, GRB | BA, 0, 0));
            q.push_back(w(B_C, L_ZLO, 0, 0, 0));
            q.push_back(w(B_ZLO, L_MAR, 0, 0, 0));
            if (op == 0) begin
                repeat (MW + 1) q.push_back(w(-1, L_MDR, 0, MRD, 0));
                q.push_back(w(B_MDR, 0, GRA | RIN, 0, 0));
            end else begin
                q.push_back(w(-1, L_MDR, GRA | ROUT, 0, 0));
                repeat (MW + 1) q.push_back(w(-1, 0, 0, RAM, 0));
            end
        end else if (op == 18) begin
            q.push_back(w(-1, L_CON, GRA | ROUT, 0, 0));
            q.push_back(w(B_PC, L_Y, 0, 0, 0));
            q.push_back(w(B_C, L_ZLO, 0, 0, 0));
            q.push_back(con ? w(B_ZLO, L_PC, 0, 0, 0) : w(-1, 0, 0, 0, 0));
        end else if (op == 19) q.push_back(w(-1, L_PC, GRA | ROUT, 0, 0));
        else if (op == 20) begin
            q.push_back(w(B_PC, 0, 0, 0, 1));
            q.push_back(w(-1, L_PC, GRA | ROUT, 0, 0));
        end else if (op == 21) q.push_back(w(B_IN, 0, GRA | RIN, 0, 0));
        else if (op == 22) q.push_back(w(-1, L_OUT, GRA | ROUT, 0, 0));
        else if (op == 23) q.push_back(w(B_HI, 0, GRA | RIN, 0, 0));
        else if (op == 24) q.push_back(w(B_LO, 0, GRA | RIN, 0, 0));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        stop = 1'b0;
        start = 1'b0;
    endtask

    // stop_idx >= 0 raises stop in that step only; -1 gives random stop/start noise.
    task automatic run_instr(input logic [4:0] op, input bit con, input int stop_idx);
        opcode = op;
        con_out = con;
        expand(op, con);
        foreach (q[i]) begin
            #1 check($sformatf("op%0d_step%0d", op, i), outs, q[i]);
            stop = stop_idx < 0 ? $urandom_range(0, 19) == 0 : i == stop_idx;
            start = stop_idx < 0 && $urandom_range(0, 9) == 0;
            pend |= stop;
            tick();
        end
        if (pend || op == 5'd26) begin
            pend = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                #1 check($sformatf("op%0d_halt", op), outs, 45'h0);
                tick();
            end
            #1 check($sformatf("op%0d_halt_start", op), outs, 45'h0);
            start = 1'b1;
            stop = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check("reset", outs, 45'h0);
        @(negedge clk) clr = 1'b1;
        tick();
        run_instr(5'd3, 1'b0, -2);
        run_instr(5'd0, 1'b0, -2);
        run_instr(5'd18, 1'b0, -2);
        run_instr(5'd18, 1'b1, -2);
        run_instr(5'd14, 1'b0, -2);
        run_instr(5'd20, 1'b0, -2);
        run_instr(5'd3, 1'b0, MW + 3);
        run_instr(5'd26, 1'b0, -2);
        run_instr(5'd2, 1'b0, -2);
        run_instr(5'd1, 1'b0, -2);
        // Reset while st sits in T6, with a stop pending that reset must discard.
        opcode = 5'd2;
        expand(5'd2, 1'b0);
        for (int i = 0; i <= MW + 6; i++) begin
            #1 check($sformatf("st_pre_rst%0d", i), outs, q[i]);
            if (i < MW + 6) tick();
        end
        stop = 1'b1;
        #1 clr = 1'b0;
        #1 check("clr_async", outs, 45'h0);
        repeat (2) begin
            @(posedge clk);
            #1 check("clr_hold", outs, 45'h0);
        end
        @(negedge clk) begin
            clr = 1'b1;
            stop = 1'b0;
        end
        tick();
        run_instr(5'd4, 1'b0, -2);
        for (int n = 0; n < 80; n++)
            run_instr(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
